// File: rtl/iir_pkg.sv
// Shared widths, output limits and the result-stage record for the decimating IIR output block.
package iir_pkg;
  localparam int SAMPLE_W = 16;
  localparam int OUT_W    = 8;
  localparam int OUT_MAX  = 127;
  localparam int OUT_MIN  = -128;

  typedef struct packed {
    logic                    valid;
    logic                    sat;
    logic signed [OUT_W-1:0] data;
  } result_t;
endpackage

// File: rtl/iir_fifo.sv
// Synchronous FIFO with occupancy output; a push into a full FIFO is accepted only alongside a pop.
module iir_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         ready,
  output logic [W-1:0] head,
  output logic         valid,
  output logic [LW-1:0] level,
  output logic         dropped
);
  localparam int AW = $clog2(DEPTH);

  // Handshake: a pop happens on an edge where valid=1 and ready=1; ready is ignored while empty.
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;
  logic          full;
  logic          accept;

  assign valid   = (level != '0);
  assign full    = (level == LW'(DEPTH));
  assign pop     = ready && valid;
  assign accept  = push && (!full || pop);
  assign dropped = push && !accept;
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/iir_decim_out.sv
// Block-averaging decimator: sums 2^DEC_LOG2 samples, rounds, saturates to 8 bits and queues results.
module iir_decim_out
  import iir_pkg::*;
#(
  parameter int DEC_LOG2   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic signed [SAMPLE_W-1:0]      data_in,
  input  logic                            in_en,
  output logic signed [OUT_W-1:0]         out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            sat,
  output logic                            overflow
);
  localparam int AW = SAMPLE_W + DEC_LOG2;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   sum;
  logic signed [AW:0]     rnd;
  logic signed [AW:0]     avg;
  logic [DEC_LOG2-1:0]    cnt;
  logic                   last;
  result_t                res;
  result_t                res_next;
  logic [OUT_W-1:0]       fifo_head;
  logic                   dropped;

  assign last = &cnt;
  assign sum  = acc + {{DEC_LOG2{data_in[SAMPLE_W-1]}}, data_in};
  // One spare bit keeps the rounding bias from wrapping a full-scale positive sum.
  assign rnd  = {sum[AW-1], sum} + (AW+1)'(2 ** (DEC_LOG2 - 1));
  assign avg  = rnd >>> DEC_LOG2;

  always_comb begin
    res_next       = '0;
    res_next.valid = in_en && last;
    if (avg > OUT_MAX) begin
      res_next.data = OUT_W'(OUT_MAX);
      res_next.sat  = 1'b1;
    end else if (avg < OUT_MIN) begin
      res_next.data = OUT_W'(OUT_MIN);
      res_next.sat  = 1'b1;
    end else begin
      res_next.data = avg[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      res      <= '0;
      sat      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (in_en) begin
        cnt <= cnt + 1'b1;
        acc <= last ? '0 : sum;
      end
      res      <= res_next;
      sat      <= res.valid && res.sat;
      overflow <= overflow || dropped;
    end
  end

  iir_fifo #(
    .W     (OUT_W),
    .DEPTH (FIFO_DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (res.valid),
    .push_data (res.data),
    .ready     (out_ready),
    .head      (fifo_head),
    .valid     (out_valid),
    .level     (fifo_level),
    .dropped   (dropped)
  );

  assign out_data = fifo_head;
endmodule

// File: doc/iir_decim_out.md
IIR_DECIM_OUT -- requirements
Module: iir_decim_out

Interface
REQ-001 The module SHALL have parameter DEC_LOG2, default 2, giving the decimation factor 2^DEC_LOG2 (legal values 1..4).
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 4, giving the output FIFO depth (power of two, at least 2).
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-005 The module SHALL have port data_in, input, 16 bits, signed: the IIR filter output sample.
REQ-006 The module SHALL have port in_en, input, 1 bit: data_in is accepted on each edge where in_en=1.
REQ-007 The module SHALL have port out_data, output, 8 bits, signed: the FIFO head sample.
REQ-008 The module SHALL have port out_valid, output, 1 bit: the FIFO is non-empty.
REQ-009 The module SHALL have port out_ready, input, 1 bit: the consumer accepts data; a pop occurs on any edge where out_valid=1 and out_ready=1.
REQ-010 The module SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: the current FIFO occupancy.
REQ-011 The module SHALL have port sat, output, 1 bit: a one-cycle pulse when the pushed result was saturated.
REQ-012 The module SHALL have port overflow, output, 1 bit: a sticky flag meaning a result was dropped because the FIFO was full.

Function
REQ-013 The accumulator SHALL be signed and 16+DEC_LOG2 bits wide, which is wide enough that it never wraps.
REQ-014 The sample counter SHALL advance only on accepted samples and SHALL wrap from 2^DEC_LOG2-1 to 0.
REQ-015 On acceptance of the sample with count=2^DEC_LOG2-1, the block SHALL compute sum = acc + data_in, register the result into the result stage, and clear acc to 0 on the same edge.
REQ-016 Rounding SHALL be avg = (sum + 2^(DEC_LOG2-1)) >>> DEC_LOG2, an arithmetic shift that rounds half toward +infinity.
REQ-017 Saturation SHALL clamp avg to the range [-128, 127]; sat SHALL pulse high in the cycle the saturated result is pushed.
REQ-018 The result stage SHALL push into the FIFO on the next edge; out_valid SHALL therefore rise 2 edges after the last sample's edge when the FIFO was empty.
REQ-019 When the FIFO is full and no pop occurs, a pushed result SHALL be dropped, overflow SHALL be set to 1, and fifo_level SHALL stay at FIFO_DEPTH.
REQ-020 A simultaneous push and pop SHALL be legal at any level, including full; the level is then unchanged and no data is dropped.
REQ-021 A pop when the FIFO is empty SHALL be impossible; out_ready is ignored while out_valid=0.
REQ-022 When the FIFO is empty, out_data SHALL read 0.
REQ-023 Output order SHALL be strictly FIFO.
REQ-024 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 Decimation SHALL continue regardless of out_ready; back-pressure never stalls the input.

Reset
REQ-026 While rst_n=0, the block SHALL clear acc, the counter, the result stage, the FIFO pointers and level, sat, and overflow to 0.
REQ-027 While rst_n=0, out_valid SHALL be 0 and out_data SHALL be 0.
REQ-028 Reset asserted mid-block SHALL discard the partial accumulation; the first block after reset starts at count 0.
REQ-029 overflow SHALL clear only on reset.

Structure
REQ-030 Shared package iir_pkg SHALL hold SAMPLE_W=16, OUT_W=8, OUT_MAX=127 and OUT_MIN=-128.
REQ-031 The FIFO SHALL be a separate sub-module iir_fifo (synchronous, with level output, parameterised width and depth); accumulation, rounding and saturation SHALL stay in iir_decim_out.

Verification (DEC_LOG2=2, FIFO_DEPTH=4, out_ready=1 unless stated)
REQ-032 Input 10,11,12,13 -> out_data=12 with out_valid for 1 cycle, 2 edges after the sample 13; sat=0.
REQ-033 Input -1,-2,-2,-2 (sum -7) -> out_data=-2; and input 4,4,4,4 -> out_data=4.
REQ-034 Input 1000 x4 -> out_data=127 with a sat pulse; input -1000 x4 -> out_data=-128 with a sat pulse.
REQ-035 With out_ready=0, feed 5 blocks of constants 1..5 -> fifo_level=4 and overflow=1; then out_ready=1 -> pops 1,2,3,4 in order, then out_valid=0; overflow stays 1.
REQ-036 Feed 7,7, then pulse rst_n low, then feed 8 x4 -> exactly one output, 8; no output from the 7s.
REQ-037 With the FIFO full and out_ready=1, complete a block on the same edge as a pop -> fifo_level stays 4, no overflow, and the new value appears last.
